// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, T-state indices and control-word bit positions
// Purpose: one place where the sequencer, datapath and bench agree on encodings.
// Ports: none (package).
package cpu_pkg;

   localparam int OPCODE_W = 4;
   localparam int T_STATES = 6;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   // Bit index of each ring state inside t_state
   localparam int T1 = 0;
   localparam int T2 = 1;
   localparam int T3 = 2;
   localparam int T4 = 3;
   localparam int T5 = 4;
   localparam int T6 = 5;

   // Control-word bit positions
   localparam int CW_CP  = 0;
   localparam int CW_EP  = 1;
   localparam int CW_LM  = 2;
   localparam int CW_CE  = 3;
   localparam int CW_LI  = 4;
   localparam int CW_EI  = 5;
   localparam int CW_LA  = 6;
   localparam int CW_EA  = 7;
   localparam int CW_SU  = 8;
   localparam int CW_EU  = 9;
   localparam int CW_LB  = 10;
   localparam int CW_LO  = 11;
   localparam int CW_HLT = 12;
   localparam int CW_W   = 13;

   typedef logic [CW_W-1:0] ctrl_word_t;

   function automatic ctrl_word_t cw_bit(input int pos);
      ctrl_word_t w;
      w = '0;
      w[pos] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot T-state ring with synchronous reset and hold
// Purpose: rotates a single 1 through T_STATES bits each clock unless held.
// Ports: clk, rst (sync, active-high), hold (freeze state), t_state (one-hot out).
module ring_counter
   import cpu_pkg::*;
#(
   parameter int N = T_STATES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   output logic [N-1:0] t_state
);

   always_ff @(posedge clk) begin
      if (rst) begin
         t_state <= {{(N-1){1'b0}}, 1'b1};
      end else if (!hold) begin
         t_state <= {t_state[N-2:0], t_state[N-1]};
      end
   end

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP control unit: ring counter plus opcode decode
// Purpose: produces the per-T-state control word for fetch and execute.
// Ports: clk, rst (sync, active-high), opcode (IR upper nibble), t_state (one-hot),
//        cp ep lm ce li ei la ea su eu lb lo (active-high controls), hlt (halted).
module controller_sequencer
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int T_STATES = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [T_STATES-1:0] t_state,
   output logic                cp,
   output logic                ep,
   output logic                lm,
   output logic                ce,
   output logic                li,
   output logic                ei,
   output logic                la,
   output logic                ea,
   output logic                su,
   output logic                eu,
   output logic                lb,
   output logic                lo,
   output logic                hlt
);

   logic       halted;
   logic       halt_now;
   ctrl_word_t cw;

   // HLT in T4 freezes the ring on the same edge that sets halted
   assign halt_now = t_state[T4] && (opcode == OP_HLT) && !halted;

   ring_counter #(.N(T_STATES)) u_ring (
      .clk     (clk),
      .rst     (rst),
      .hold    (halted || halt_now),
      .t_state (t_state)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         halted <= 1'b0;
      end else if (halt_now) begin
         halted <= 1'b1;
      end
   end

   always_comb begin
      cw = '0;
      if (halted) begin
         cw = cw_bit(CW_HLT);
      end else if (t_state[T1]) begin
         cw = cw_bit(CW_EP) | cw_bit(CW_LM);
      end else if (t_state[T2]) begin
         cw = cw_bit(CW_CP);
      end else if (t_state[T3]) begin
         cw = cw_bit(CW_CE) | cw_bit(CW_LI);
      end else if (t_state[T4]) begin
         case (opcode)
            OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_EI) | cw_bit(CW_LM);
            OP_OUT:                 cw = cw_bit(CW_EA) | cw_bit(CW_LO);
            OP_HLT:                 cw = cw_bit(CW_HLT);
            default:                cw = '0;
         endcase
      end else if (t_state[T5]) begin
         case (opcode)
            OP_LDA:         cw = cw_bit(CW_CE) | cw_bit(CW_LA);
            OP_ADD, OP_SUB: cw = cw_bit(CW_CE) | cw_bit(CW_LB);
            default:        cw = '0;
         endcase
      end else if (t_state[T6]) begin
         case (opcode)
            OP_ADD:  cw = cw_bit(CW_EU) | cw_bit(CW_LA);
            OP_SUB:  cw = cw_bit(CW_EU) | cw_bit(CW_LA) | cw_bit(CW_SU);
            default: cw = '0;
         endcase
      end
   end

   assign cp  = cw[CW_CP];
   assign ep  = cw[CW_EP];
   assign lm  = cw[CW_LM];
   assign ce  = cw[CW_CE];
   assign li  = cw[CW_LI];
   assign ei  = cw[CW_EI];
   assign la  = cw[CW_LA];
   assign ea  = cw[CW_EA];
   assign su  = cw[CW_SU];
   assign eu  = cw[CW_EU];
   assign lb  = cw[CW_LB];
   assign lo  = cw[CW_LO];
   assign hlt = cw[CW_HLT];

   a_bus_exclusive: assert property (@(posedge clk) disable iff (rst)
      $onehot0({ep, ce, ei, ea, eu}));

   a_ring_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot(t_state));

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - table-driven bench for controller_sequencer
module tb_controller_sequencer;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic [5:0] t_state;
   logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
   ctrl_word_t act;

   int n_tests = 0;
   int n_fail  = 0;

   localparam ctrl_word_t Z   = '0;
   localparam ctrl_word_t MCP = ctrl_word_t'(1) << CW_CP;
   localparam ctrl_word_t MEP = ctrl_word_t'(1) << CW_EP;
   localparam ctrl_word_t MLM = ctrl_word_t'(1) << CW_LM;
   localparam ctrl_word_t MCE = ctrl_word_t'(1) << CW_CE;
   localparam ctrl_word_t MLI = ctrl_word_t'(1) << CW_LI;
   localparam ctrl_word_t MEI = ctrl_word_t'(1) << CW_EI;
   localparam ctrl_word_t MLA = ctrl_word_t'(1) << CW_LA;
   localparam ctrl_word_t MEA = ctrl_word_t'(1) << CW_EA;
   localparam ctrl_word_t MSU = ctrl_word_t'(1) << CW_SU;
   localparam ctrl_word_t MEU = ctrl_word_t'(1) << CW_EU;
   localparam ctrl_word_t MLB = ctrl_word_t'(1) << CW_LB;
   localparam ctrl_word_t MLO = ctrl_word_t'(1) << CW_LO;
   localparam ctrl_word_t MHL = ctrl_word_t'(1) << CW_HLT;

   typedef struct {
      logic       r;
      logic [3:0] op;
      logic [5:0] t;
      ctrl_word_t cw;
   } vec_t;

   vec_t vecs[$];

   controller_sequencer #(.OPCODE_W(4), .T_STATES(6)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .t_state(t_state),
      .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
      .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
   );

   always #5 clk = ~clk;

   always_comb begin
      act = '0;
      act[CW_CP] = cp;  act[CW_EP] = ep;  act[CW_LM] = lm;  act[CW_CE] = ce;
      act[CW_LI] = li;  act[CW_EI] = ei;  act[CW_LA] = la;  act[CW_EA] = ea;
      act[CW_SU] = su;  act[CW_EU] = eu;  act[CW_LB] = lb;  act[CW_LO] = lo;
      act[CW_HLT] = hlt;
   end

   task automatic add(input logic r, input logic [3:0] op, input logic [5:0] t,
                      input ctrl_word_t c);
      vec_t v;
      v.r = r; v.op = op; v.t = t; v.cw = c;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [15:0] got,
                        input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
      end
   endtask

   // Drive inputs just after the falling edge, then let outputs settle
   task automatic cyc(input logic r, input logic [3:0] op);
      @(negedge clk);
      rst = r;
      opcode = op;
      #1;
   endtask

   logic [7:0] acc, breg, bus;
   logic [3:0] rop;
   logic       undef_op;

   initial begin
      // OUT: full fetch/execute and wrap back to T1 (first row checks reset state)
      add(0, 4'hE, 6'h01, MEP | MLM);
      add(0, 4'hE, 6'h02, MCP);
      add(0, 4'hE, 6'h04, MCE | MLI);
      add(0, 4'hE, 6'h08, MEA | MLO);
      add(0, 4'hE, 6'h10, Z);
      add(0, 4'hE, 6'h20, Z);
      // ADD
      add(0, 4'h1, 6'h01, MEP | MLM);
      add(0, 4'h1, 6'h02, MCP);
      add(0, 4'h1, 6'h04, MCE | MLI);
      add(0, 4'h1, 6'h08, MEI | MLM);
      add(0, 4'h1, 6'h10, MCE | MLB);
      add(0, 4'h1, 6'h20, MEU | MLA);
      // SUB
      add(0, 4'h2, 6'h01, MEP | MLM);
      add(0, 4'h2, 6'h02, MCP);
      add(0, 4'h2, 6'h04, MCE | MLI);
      add(0, 4'h2, 6'h08, MEI | MLM);
      add(0, 4'h2, 6'h10, MCE | MLB);
      add(0, 4'h2, 6'h20, MEU | MLA | MSU);
      // LDA
      add(0, 4'h0, 6'h01, MEP | MLM);
      add(0, 4'h0, 6'h02, MCP);
      add(0, 4'h0, 6'h04, MCE | MLI);
      add(0, 4'h0, 6'h08, MEI | MLM);
      add(0, 4'h0, 6'h10, MCE | MLA);
      add(0, 4'h0, 6'h20, Z);
      // Undefined opcode 7 is a NOP in execute
      add(0, 4'h7, 6'h01, MEP | MLM);
      add(0, 4'h7, 6'h02, MCP);
      add(0, 4'h7, 6'h04, MCE | MLI);
      add(0, 4'h7, 6'h08, Z);
      add(0, 4'h7, 6'h10, Z);
      add(0, 4'h7, 6'h20, Z);
      // HLT: freeze at T4 for 10 cycles despite opcode changes, then reset out
      add(0, 4'hF, 6'h01, MEP | MLM);
      add(0, 4'hF, 6'h02, MCP);
      add(0, 4'hF, 6'h04, MCE | MLI);
      add(0, 4'hF, 6'h08, MHL);
      for (int i = 0; i < 10; i++) add(0, (i % 2 == 0) ? 4'h1 : 4'hF, 6'h08, MHL);
      add(1, 4'h1, 6'h08, MHL);
      add(0, 4'h1, 6'h01, MEP | MLM);
      // ADD aborted by reset in T5
      add(0, 4'h1, 6'h02, MCP);
      add(0, 4'h1, 6'h04, MCE | MLI);
      add(0, 4'h1, 6'h08, MEI | MLM);
      add(1, 4'h1, 6'h10, MCE | MLB);
      add(0, 4'h1, 6'h01, MEP | MLM);
      add(0, 4'h1, 6'h02, MCP);
      add(0, 4'h1, 6'h04, MCE | MLI);

      // Reset is held from time 0 through the first rising edge
      @(negedge clk);
      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         rst = vecs[i].r;
         opcode = vecs[i].op;
         #1;
         check("t_state", i, 16'(t_state), 16'(vecs[i].t));
         check("ctrl", i, 16'(act), 16'(vecs[i].cw));
      end

      // Adder integration: ADD 5+5 and SUB 5-10 observed on a modelled w_bus
      acc = 8'd5;
      for (int k = 0; k < 2; k++) begin
         breg = (k == 0) ? 8'd5 : 8'd10;
         cyc(1, 4'h0);
         for (int c = 0; c < 6; c++) begin
            cyc(0, (k == 0) ? 4'h1 : 4'h2);
            bus = 8'h00;
            if (eu) bus = su ? (acc - breg) : (acc + breg);
            if (c == 5) begin
               check("t6_onehot", k, 16'(t_state), 16'h0020);
               check("t6_su", k, 16'(su), (k == 0) ? 16'h0 : 16'h1);
               check("t6_w_bus", k, 16'(bus), (k == 0) ? 16'h000A : 16'h00FB);
            end else begin
               check("su_low", k * 6 + c, 16'(su), 16'h0);
            end
         end
      end

      // Random opcodes; any halt is cleared by reset on the following edge
      cyc(1, 4'h0);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         rst = 1'b0;
         rop = 4'($urandom_range(0, 15));
         opcode = rop;
         #1;
         check("rand_onehot", i, 16'($onehot(t_state)), 16'h1);
         check("rand_excl", i, 16'($onehot0({ep, ce, ei, ea, eu})), 16'h1);
         undef_op = !(rop inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF});
         if (!hlt && undef_op && (t_state[T4] || t_state[T5] || t_state[T6]))
            check("rand_nop", i, 16'(act), 16'h0);
         if (hlt) begin
            check("rand_halt_t4", i, 16'(t_state), 16'h0008);
            rst = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
Control unit of the 8-bit SAP-style datapath. A one-hot six-state ring counter (T1..T6) combines with the 4-bit opcode from the instruction register to generate the per-cycle control word. That word includes su and eu, which drive adder_subtractor directly. The block sits upstream of every datapath register and of the adder/subtractor, and orchestrates fetch and execute on the shared 8-bit w_bus.

Parameters:
OPCODE_W, 4, width of the opcode field taken from the instruction register's upper nibble.
T_STATES, 6, number of ring-counter states (fixed at 6; parameter exists only for documentation and assertion use).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
opcode  input  OPCODE_W  instruction-register upper nibble; valid from T4 onward.
t_state  output  6  one-hot ring state; bit0 = T1 ... bit5 = T6.
cp  output  1  program counter increment.
ep  output  1  program counter drives w_bus.
lm  output  1  MAR load from w_bus.
ce  output  1  RAM drives w_bus.
li  output  1  instruction register load.
ei  output  1  instruction register operand nibble drives w_bus.
la  output  1  accumulator load.
ea  output  1  accumulator drives w_bus.
su  output  1  adder_subtractor mode (1 = subtract).
eu  output  1  adder_subtractor drives w_bus.
lb  output  1  register B load.
lo  output  1  output register load.
hlt  output  1  machine halted; clock-gating/stop indicator.

Behaviour:
- All control outputs are active-high.
- All control outputs are combinational decodes of t_state, opcode, and the internal halted flag. No extra latency: a control is valid in the same cycle as its T-state.
- Reset: when rst = 1 at a rising edge, t_state <= 6'b000001 (T1) and halted <= 0. This applies from any state, including mid-instruction and while halted.
  - While in T1 after reset, the outputs are ep = 1 and lm = 1; every other control output is 0 and hlt = 0.
- Ring counter: advances T1->T2->...->T6->T1 on each edge when not halted. Must remain one-hot at all times.
- Fetch (opcode ignored):
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- Execute, T4..T6 (opcode constants live in the package):
  - LDA 4'h0: T4 ei, lm; T5 ce, la; T6 none.
  - ADD 4'h1: T4 ei, lm; T5 ce, lb; T6 eu, la, su = 0.
  - SUB 4'h2: T4 ei, lm; T5 ce, lb; T6 eu, la, su = 1.
  - OUT 4'hE: T4 ea, lo; T5 none; T6 none.
  - HLT 4'hF: in T4, hlt = 1 combinationally and all other controls are 0. At the T4 edge, halted <= 1 and t_state holds at T4.
  - Any other opcode: NOP, with all controls 0 in T4..T6.
- Halted:
  - t_state is frozen at T4, all controls are 0, and hlt = 1.
  - Only rst exits this state.
  - opcode changes have no effect while halted.
- su is asserted only in T6 of SUB; it is 0 in every other cycle.
- Bus-driver exclusivity: at most one of {ep, ce, ei, ea, eu} is high in any cycle. Embed this as an assertion.
- Load signals (lm, li, la, lb, lo) take effect at the rising edge that ends the current T-state.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - T-state index constants T1..T6;
  - the control-word bit positions, so the datapath and bench decode identically.
- One natural sub-module, ring_counter: 6-bit one-hot shifter with synchronous rst and a hold input, driven by halted.
- Instruction decode stays in controller_sequencer.

Test Plan:
- Apply rst for 1 cycle, then free-run with opcode = 4'hE -> t_state sequence 01,02,04,08,10,20,01. Control words per cycle: T1 ep+lm; T2 cp; T3 ce+li; T4 ea+lo; T5/T6 all 0.
- opcode = 4'h1 (ADD) -> T5 asserts ce+lb; T6 asserts eu+la with su = 0. Integrated with adder_subtractor, accumulator 5 and B 5 give w_bus = 8'h0A in T6.
- opcode = 4'h2 (SUB), accumulator 5 and B 10 -> T6: su = 1, eu = 1, la = 1, and w_bus = 8'hFB. su is 0 in every other cycle.
- opcode = 4'hF -> hlt rises in T4. The next 10 cycles show t_state = 08, hlt = 1, all controls 0, even with opcode toggled to 4'h1. Then rst for 1 cycle -> t_state = 01, hlt = 0.
- Assert rst during T5 of an ADD -> next cycle t_state = 01 with only ep and lm high. The lb/eu steps of the aborted instruction never appear.
- Run 200 cycles with random opcodes -> exclusivity assertion never fires, t_state is always one-hot, and undefined opcodes (e.g. 4'h7) produce all-zero controls in T4..T6.
